nf_router_arb: RTL and testbench

- Round-robin arbiter and transaction sequencer that shares the single load/store bus between Master_n masters (e.g. data LSU and debug/DMA port).
- Sits upstream of the router address decoder.
- Grants one master at a time and holds its address and data stable toward the router until the selected slave acks.
- Returns read data with a one-cycle ack, and raises an error ack if the slave never answers.

---
 rtl/nf_router_arb.sv | 169 ++++++++++++++++
 tb/tb_nf_router_arb.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/nf_router_arb.sv
// nf_router_arb: round-robin arbiter and transaction sequencer that shares the
// single load/store bus between Master_n masters. The granted master's address,
// write enable and write data are held stable toward the router decoder until
// the selected slave acks, or until the busy timeout expires and the
// transaction completes with an error.
//
// state     | meaning
// ----------+------------------------------------------------------------------
// ST_IDLE   | bus free; pick the next owner round-robin from last_grant + 1
// ST_BUSY   | req_s high, operands frozen, waiting for ack_s or the timeout
// ST_RESP   | one-cycle ack_m pulse to the owner with rd_m / err_m valid

module nf_router_arb #(
    parameter int Master_n = 2,
    parameter int TIMEOUT  = 16
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [Master_n-1:0]         req_m,
    input  logic [Master_n*32-1:0]      addr_m,
    input  logic [Master_n-1:0]         we_m,
    input  logic [Master_n*32-1:0]      wd_m,
    output logic [Master_n-1:0]         ack_m,
    output logic [31:0]                 rd_m,
    output logic                        err_m,
    output logic [$clog2(Master_n)-1:0] gnt_id,
    output logic [31:0]                 addr_s,
    output logic                        we_s,
    output logic [31:0]                 wd_s,
    output logic                        req_s,
    input  logic [31:0]                 rd_s,
    input  logic                        ack_s
);

    localparam int GW = $clog2(Master_n);
    // The counter only has to reach TIMEOUT-1 before the transaction is closed.
    localparam int CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0] CNT_LAST = (TIMEOUT > 0) ? CW'(TIMEOUT - 1) : '0;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_BUSY,
        ST_RESP
    } state_t;

    state_t              state_q;
    logic [CW-1:0]       cnt_q;
    logic [GW-1:0]       last_q;
    logic [GW-1:0]       gnt_q;
    logic [Master_n-1:0] ack_q;
    logic [31:0]         rd_q;
    logic                err_q;
    logic [31:0]         addr_q;
    logic                we_q;
    logic [31:0]         wd_q;
    logic                req_q;

    logic [Master_n-1:0] req_hi;
    logic                win_vld;
    logic [GW-1:0]       win_d;
    logic [31:0]         win_addr_d;
    logic                win_we_d;
    logic [31:0]         win_wd_d;

    // Round-robin pick: lowest requester above last_q, else lowest overall (wrap).
    always_comb begin
        req_hi  = '0;
        win_vld = |req_m;
        win_d   = '0;
        for (int i = 0; i < Master_n; i++) begin
            req_hi[i] = req_m[i] && (GW'(i) > last_q);
        end
        for (int i = Master_n - 1; i >= 0; i--) begin
            if (req_m[i]) begin
                win_d = GW'(i);
            end
        end
        if (|req_hi) begin
            for (int i = Master_n - 1; i >= 0; i--) begin
                if (req_hi[i]) begin
                    win_d = GW'(i);
                end
            end
        end
    end

    // Select the winner's operands out of the packed per-master buses.
    always_comb begin
        win_addr_d = '0;
        win_we_d   = 1'b0;
        win_wd_d   = '0;
        for (int i = 0; i < Master_n; i++) begin
            if (GW'(i) == win_d) begin
                win_addr_d = addr_m[i*32 +: 32];
                win_we_d   = we_m[i];
                win_wd_d   = wd_m[i*32 +: 32];
            end
        end
    end

    // Arbitration, operand hold, completion/timeout sequencing; all outputs registered.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            last_q  <= GW'(Master_n - 1);
            gnt_q   <= '0;
            ack_q   <= '0;
            rd_q    <= '0;
            err_q   <= 1'b0;
            addr_q  <= '0;
            we_q    <= 1'b0;
            wd_q    <= '0;
            req_q   <= 1'b0;
        end else begin
            ack_q <= '0;
            case (state_q)
                ST_IDLE: begin
                    if (win_vld) begin
                        gnt_q   <= win_d;
                        addr_q  <= win_addr_d;
                        we_q    <= win_we_d;
                        wd_q    <= win_wd_d;
                        req_q   <= 1'b1;
                        cnt_q   <= '0;
                        state_q <= ST_BUSY;
                    end else begin
                        req_q <= 1'b0;
                    end
                end
                ST_BUSY: begin
                    cnt_q <= cnt_q + 1'b1;
                    // A slave answer on the timeout cycle still counts as success.
                    if (ack_s) begin
                        rd_q    <= rd_s;
                        err_q   <= 1'b0;
                        req_q   <= 1'b0;
                        ack_q   <= Master_n'(1) << gnt_q;
                        state_q <= ST_RESP;
                    end else if (TIMEOUT != 0 && cnt_q == CNT_LAST) begin
                        rd_q    <= '0;
                        err_q   <= 1'b1;
                        req_q   <= 1'b0;
                        ack_q   <= Master_n'(1) << gnt_q;
                        state_q <= ST_RESP;
                    end
                end
                ST_RESP: begin
                    last_q  <= gnt_q;
                    err_q   <= 1'b0;
                    state_q <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign ack_m  = ack_q;
    assign rd_m   = rd_q;
    assign err_m  = err_q;
    assign gnt_id = gnt_q;
    assign addr_s = addr_q;
    assign we_s   = we_q;
    assign wd_s   = wd_q;
    assign req_s  = req_q;

endmodule

// File: tb/tb_nf_router_arb.sv
// Bench for nf_router_arb: directed scenarios with literal expectations plus a
// randomized phase, all checked each cycle against a transaction-level model.

module tb_nf_router_arb;

    localparam int N  = 2;
    localparam int TO = 16;

    logic              clk = 1'b0;
    logic              reset;
    logic [N-1:0]      req_m;
    logic [N*32-1:0]   addr_m;
    logic [N-1:0]      we_m;
    logic [N*32-1:0]   wd_m;
    logic [N-1:0]      ack_m;
    logic [31:0]       rd_m;
    logic              err_m;
    logic [$clog2(N)-1:0] gnt_id;
    logic [31:0]       addr_s;
    logic              we_s;
    logic [31:0]       wd_s;
    logic              req_s;
    logic [31:0]       rd_s;
    logic              ack_s;

    int vectors = 0;
    int miscompares = 0;

    nf_router_arb #(.Master_n(N), .TIMEOUT(TO)) dut (
        .clk    (clk),
        .reset  (reset),
        .req_m  (req_m),
        .addr_m (addr_m),
        .we_m   (we_m),
        .wd_m   (wd_m),
        .ack_m  (ack_m),
        .rd_m   (rd_m),
        .err_m  (err_m),
        .gnt_id (gnt_id),
        .addr_s (addr_s),
        .we_s   (we_s),
        .wd_s   (wd_s),
        .req_s  (req_s),
        .rd_s   (rd_s),
        .ack_s  (ack_s)
    );

    always #5 clk = ~clk;

    // Transaction-level reference: phase 0 free, 1 owned and waiting, 2 answering.
    int          m_phase, m_owner, m_last, m_wait, m_c;
    bit          m_found;
    logic [N-1:0] e_ack;
    logic [31:0] e_rd, e_addr, e_wd;
    logic        e_err, e_we, e_req;

    always @(posedge clk) begin
        if (reset) begin
            m_phase = 0; m_owner = 0; m_last = N - 1; m_wait = 0;
            e_ack = '0; e_rd = '0; e_err = 1'b0;
            e_addr = '0; e_wd = '0; e_we = 1'b0; e_req = 1'b0;
        end else begin
            e_ack = '0;
            if (m_phase == 0) begin
                m_found = 1'b0;
                for (int k = 1; k <= N; k++) begin
                    m_c = (m_last + k) % N;
                    if (!m_found && req_m[m_c]) begin
                        m_found = 1'b1;
                        m_owner = m_c;
                    end
                end
                if (m_found) begin
                    e_addr  = 32'(addr_m >> (32 * m_owner));
                    e_wd    = 32'(wd_m >> (32 * m_owner));
                    e_we    = we_m[m_owner];
                    e_req   = 1'b1;
                    m_wait  = 0;
                    m_phase = 1;
                end
            end else if (m_phase == 1) begin
                m_wait++;
                if (ack_s) begin
                    e_rd = rd_s; e_err = 1'b0; e_req = 1'b0;
                    e_ack[m_owner] = 1'b1; m_phase = 2;
                end else if (TO != 0 && m_wait == TO) begin
                    e_rd = '0; e_err = 1'b1; e_req = 1'b0;
                    e_ack[m_owner] = 1'b1; m_phase = 2;
                end
            end else begin
                m_last  = m_owner;
                e_err   = 1'b0;
                m_phase = 0;
            end
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Advance one clock and compare every output against the model.
    task automatic cyc();
        @(posedge clk);
        #1;
        chk("ack_m",  32'(ack_m),  32'(e_ack));
        chk("rd_m",   rd_m,        e_rd);
        chk("err_m",  32'(err_m),  32'(e_err));
        chk("gnt_id", 32'(gnt_id), 32'(m_owner));
        chk("addr_s", addr_s,      e_addr);
        chk("we_s",   32'(we_s),   32'(e_we));
        chk("wd_s",   wd_s,        e_wd);
        chk("req_s",  32'(req_s),  32'(e_req));
    endtask

    task automatic do_reset();
        reset = 1'b1;
        req_m = '0; ack_s = 1'b0;
        cyc();
        reset = 1'b0;
    endtask

    task automatic new_req(input int i);
        req_m[i]           = 1'b1;
        addr_m[i*32 +: 32] = $urandom;
        we_m[i]            = 1'($urandom_range(0, 1));
        wd_m[i*32 +: 32]   = $urandom;
    endtask

    int hi;

    initial begin
        reset = 1'b1; req_m = '0; addr_m = '0; we_m = '0; wd_m = '0;
        rd_s = '0; ack_s = 1'b0;
        cyc();
        chk("rst_req_s", 32'(req_s), 32'd0);
        chk("rst_ack_m", 32'(ack_m), 32'd0);
        chk("rst_gnt",   32'(gnt_id), 32'd0);
        cyc();

        // Single read from master 0
        reset = 1'b0;
        req_m = 2'b01; addr_m[31:0] = 32'h0001_0004; we_m = '0;
        cyc();
        chk("rd_req_s", 32'(req_s), 32'd1);
        chk("rd_addr_s", addr_s, 32'h0001_0004);
        ack_s = 1'b1; rd_s = 32'h1234_5678;
        cyc();
        chk("rd_ack", 32'(ack_m), 32'h1);
        chk("rd_data", rd_m, 32'h1234_5678);
        chk("rd_err", 32'(err_m), 32'd0);
        req_m = '0; ack_s = 1'b0; rd_s = 32'hDEAD_BEEF;
        cyc();
        chk("rd_ack_clr", 32'(ack_m), 32'd0);
        chk("rd_hold", rd_m, 32'h1234_5678);

        // Contention and fairness: both masters hold req, slave acks at once
        do_reset();
        req_m = 2'b11;
        addr_m[31:0] = 32'h0000_1000; addr_m[63:32] = 32'h0000_2000;
        ack_s = 1'b1; rd_s = 32'h0F0F_0F0F;
        for (int t = 0; t < 6; t++) begin
            cyc();
            chk("fair_gnt", 32'(gnt_id), 32'(t % 2));
            chk("fair_addr", addr_s, (t % 2 == 1) ? 32'h0000_2000 : 32'h0000_1000);
            cyc();
            chk("fair_ack", 32'(ack_m), (t % 2 == 1) ? 32'h2 : 32'h1);
            cyc();
            chk("fair_ack_w", 32'(ack_m), 32'd0);
        end

        // Timeout on a write that is never answered
        do_reset();
        req_m = 2'b01; addr_m[31:0] = 32'h0003_0000; we_m = 2'b01;
        wd_m[31:0] = 32'h55AA_55AA; ack_s = 1'b0;
        cyc();
        chk("to_we_s", 32'(we_s), 32'd1);
        hi = req_s ? 1 : 0;
        for (int k = 0; k < 40; k++) begin
            cyc();
            if (!req_s) break;
            hi++;
        end
        chk("to_req_cycles", 32'(hi), 32'd16);
        chk("to_ack", 32'(ack_m), 32'h1);
        chk("to_err", 32'(err_m), 32'd1);
        chk("to_rd", rd_m, 32'd0);
        req_m = '0; we_m = '0;
        cyc();
        chk("to_err_clr", 32'(err_m), 32'd0);

        // Ack on the timeout cycle wins; owner drops req mid-transaction
        do_reset();
        req_m = 2'b10; addr_m[63:32] = 32'h0004_0008;
        cyc();
        chk("co_gnt", 32'(gnt_id), 32'd1);
        for (int k = 0; k < 15; k++) begin
            if (k == 5) req_m = '0;
            cyc();
        end
        chk("co_req_s", 32'(req_s), 32'd1);
        ack_s = 1'b1; rd_s = 32'hCAFE_F00D;
        cyc();
        chk("co_ack", 32'(ack_m), 32'h2);
        chk("co_err", 32'(err_m), 32'd0);
        chk("co_rd", rd_m, 32'hCAFE_F00D);
        ack_s = 1'b0;
        cyc();

        // Reset during the third busy cycle aborts without an ack
        do_reset();
        req_m = 2'b01; addr_m[31:0] = 32'h0005_0000;
        cyc(); cyc(); cyc();
        reset = 1'b1;
        cyc();
        chk("ab_req_s", 32'(req_s), 32'd0);
        chk("ab_ack", 32'(ack_m), 32'd0);
        reset = 1'b0; req_m = 2'b10; addr_m[63:32] = 32'h0006_0000;
        cyc();
        chk("ab_gnt", 32'(gnt_id), 32'd1);
        chk("ab_addr", addr_s, 32'h0006_0000);
        ack_s = 1'b1; rd_s = 32'h0BAD_F00D;
        cyc();
        chk("ab_ack2", 32'(ack_m), 32'h2);
        ack_s = 1'b0; req_m = '0;
        cyc();

        // Randomized traffic with quiet slave windows and occasional resets
        for (int n = 0; n < 3000; n++) begin
            for (int i = 0; i < N; i++) begin
                if (ack_m[i]) begin
                    if ($urandom_range(0, 3) == 0) new_req(i);
                    else req_m[i] = 1'b0;
                end else if (!req_m[i]) begin
                    if ($urandom_range(0, 2) == 0) new_req(i);
                end else if ($urandom_range(0, 63) == 0) begin
                    req_m[i] = 1'b0;
                end
            end
            ack_s = (n % 250 < 50) ? 1'b0 : ($urandom_range(0, 2) == 0);
            rd_s  = $urandom;
            reset = ($urandom_range(0, 399) == 0);
            cyc();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
